// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core widths plus the fetch-stage entry, cause and state types.
package riscv_pkg;
    localparam int XLEN     = 32;
    localparam int MEM_SIZE = 1024;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_RANGE    = 2'd2
    } fetch_cause_e;

    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_FAULT = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch entries with push/pop/flush and occupancy count.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_data,
    output logic         o_valid,
    output logic [AW:0]  o_count
);
    fetch_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_data;
    end

    assign o_valid = r_cnt != '0;
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, imem fetch into a small FIFO, redirect handling and
// a sticky fault on misaligned or out-of-range PCs.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              DEPTH        = 2,
    parameter int              MEM_SIZE     = riscv_pkg::MEM_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_instr_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o,
    output logic            fault_o,
    output logic [1:0]      fault_cause_o
);
    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(MEM_SIZE * 4);

    fetch_state_e    r_state;
    fetch_cause_e    r_cause;
    logic [XLEN-1:0] r_pc;
    logic            w_run;
    logic            w_misalign;
    logic            w_range;
    logic            w_pop;
    logic            w_push;
    logic [CW-1:0]   w_count;
    fetch_entry_t    w_head;

    assign w_run      = r_state == FS_RUN;
    assign w_misalign = r_pc[1:0] != 2'b00;
    assign w_range    = r_pc >= PC_LIMIT;
    assign w_pop      = if_valid_o & if_ready_i & ~redirect_i;
    assign w_push     = w_run & ~redirect_i & ~w_misalign & ~w_range
                        & ((w_count < CW'(DEPTH)) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FS_RUN;
            r_cause <= FC_NONE;
            r_pc    <= RESET_VECTOR;
        end else if (w_run) begin
            if (redirect_i) begin
                r_pc <= redirect_pc_i;
            end else if (w_misalign) begin
                r_state <= FS_FAULT;
                r_cause <= FC_MISALIGN;
            end else if (w_range) begin
                r_state <= FS_FAULT;
                r_cause <= FC_RANGE;
            end else if (w_push) begin
                r_pc <= r_pc + XLEN'(4);
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_run & redirect_i),
        .i_data  ('{pc: r_pc, instr: imem_instr_i}),
        .o_data  (w_head),
        .o_valid (if_valid_o),
        .o_count (w_count)
    );

    assign imem_addr_o   = r_pc;
    assign if_pc_o       = w_head.pc;
    assign if_instr_o    = w_head.instr;
    assign fault_o       = r_state == FS_FAULT;
    assign fault_cause_o = r_cause;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: two fetch units (default and 16-word memory) driven in lockstep and
// checked every cycle against a queue-level model plus hand-computed expectations.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] rpc = '0;

    logic [31:0] d_addr [2];
    logic [31:0] d_imem [2];
    logic [31:0] d_pc   [2];
    logic [31:0] d_ins  [2];
    logic        d_valid[2];
    logic        d_fault[2];
    logic [1:0]  d_cause[2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign d_imem[0] = d_addr[0] ^ 32'hA5A5_0000;
    assign d_imem[1] = d_addr[1] ^ 32'hA5A5_0000;

    fetch_unit #(.RESET_VECTOR(32'h0), .DEPTH(DEPTH)) u0 (
        .clk(clk), .rst_n(rst_n), .imem_addr_o(d_addr[0]), .imem_instr_i(d_imem[0]),
        .redirect_i(redirect), .redirect_pc_i(rpc), .if_valid_o(d_valid[0]),
        .if_ready_i(ready), .if_pc_o(d_pc[0]), .if_instr_o(d_ins[0]),
        .fault_o(d_fault[0]), .fault_cause_o(d_cause[0])
    );

    fetch_unit #(.RESET_VECTOR(32'h0), .DEPTH(DEPTH), .MEM_SIZE(16)) u1 (
        .clk(clk), .rst_n(rst_n), .imem_addr_o(d_addr[1]), .imem_instr_i(d_imem[1]),
        .redirect_i(redirect), .redirect_pc_i(rpc), .if_valid_o(d_valid[1]),
        .if_ready_i(ready), .if_pc_o(d_pc[1]), .if_instr_o(d_ins[1]),
        .fault_o(d_fault[1]), .fault_cause_o(d_cause[1])
    );

    // Model: per-instance PC, fault flag/cause and an in-order list of buffered entries.
    logic [31:0] m_pc   [2];
    logic        m_fault[2];
    logic [1:0]  m_cause[2];
    int          m_cnt  [2];
    logic [31:0] m_qpc  [2][DEPTH];
    logic [31:0] m_qin  [2][DEPTH];

    function automatic logic [31:0] lim(input int k);
        return k == 0 ? 32'h1000 : 32'h40;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h0;
            m_fault[k] = 1'b0;
            m_cause[k] = 2'd0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!m_fault[k] && redirect) begin
                m_cnt[k] = 0;
                m_pc[k] = rpc;
            end else begin
                if (m_cnt[k] > 0 && ready && !redirect) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        m_qpc[k][i] = m_qpc[k][i+1];
                        m_qin[k][i] = m_qin[k][i+1];
                    end
                    m_cnt[k]--;
                end
                if (!m_fault[k]) begin
                    if (m_pc[k] % 4 != 0) begin
                        m_fault[k] = 1'b1;
                        m_cause[k] = 2'd1;
                    end else if (m_pc[k] >= lim(k)) begin
                        m_fault[k] = 1'b1;
                        m_cause[k] = 2'd2;
                    end else if (m_cnt[k] < DEPTH) begin
                        m_qpc[k][m_cnt[k]] = m_pc[k];
                        m_qin[k][m_cnt[k]] = m_pc[k] ^ 32'hA5A5_0000;
                        m_cnt[k]++;
                        m_pc[k] = m_pc[k] + 32'd4;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d_valid", k), 32'(d_valid[k]), 32'(m_cnt[k] > 0));
            chk($sformatf("u%0d_pc", k), d_pc[k], m_cnt[k] > 0 ? m_qpc[k][0] : 32'h0);
            chk($sformatf("u%0d_instr", k), d_ins[k], m_cnt[k] > 0 ? m_qin[k][0] : 32'h0);
            chk($sformatf("u%0d_addr", k), d_addr[k], m_pc[k]);
            chk($sformatf("u%0d_fault", k), 32'(d_fault[k]), 32'(m_fault[k]));
            chk($sformatf("u%0d_cause", k), 32'(d_cause[k]), 32'(m_cause[k]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1 compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare();
        chk("async_rst_valid", 32'(d_valid[0]), 32'h0);
        chk("async_rst_addr", d_addr[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 compare();
    endtask

    initial begin
        model_reset();
        #7 compare();
        chk("rst_valid", 32'(d_valid[0]), 32'h0);
        chk("rst_cause", 32'(d_cause[0]), 32'h0);
        // Streaming with decode always ready: one entry per cycle, no bubbles.
        ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t1_head_pc", d_pc[0], 32'(i * 4));
            chk("t1_head_instr", d_ins[0], 32'(i * 4) ^ 32'hA5A5_0000);
            chk("t1_valid", 32'(d_valid[0]), 32'h1);
        end
        // Backpressure from reset: FIFO fills, PC holds, head stays put.
        ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) cyc();
        chk("t2_hold_addr", d_addr[0], 32'h8);
        chk("t2_hold_head", d_pc[0], 32'h0);
        ready = 1'b1;
        cyc();
        chk("t2_drain1", d_pc[0], 32'h4);
        cyc();
        chk("t2_drain2", d_pc[0], 32'h8);
        // Redirect while full and ready.
        redirect = 1'b1;
        rpc = 32'h40;
        cyc();
        redirect = 1'b0;
        chk("t3_bubble", 32'(d_valid[0]), 32'h0);
        chk("t3_addr", d_addr[0], 32'h40);
        cyc();
        chk("t3_head40", d_pc[0], 32'h40);
        chk("t3_u1_range", 32'(d_cause[1]), 32'h2);
        cyc();
        chk("t3_head44", d_pc[0], 32'h44);
        // Misaligned redirect faults; later redirects are ignored.
        ready = 1'b0;
        redirect = 1'b1;
        rpc = 32'h42;
        cyc();
        redirect = 1'b0;
        cyc();
        chk("t4_fault", 32'(d_fault[0]), 32'h1);
        chk("t4_cause", 32'(d_cause[0]), 32'h1);
        redirect = 1'b1;
        rpc = 32'h100;
        cyc();
        redirect = 1'b0;
        cyc();
        chk("t4_ignored_addr", d_addr[0], 32'h42);
        chk("t4_sticky", 32'(d_fault[0]), 32'h1);
        // Running off the end of a 16-word memory, then draining buffered entries.
        redirect = 1'b1;
        rpc = 32'h38;
        do_reset();
        cyc();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("t5_fault", 32'(d_fault[1]), 32'h1);
        chk("t5_cause", 32'(d_cause[1]), 32'h2);
        chk("t5_head38", d_pc[1], 32'h38);
        chk("t5_addr", d_addr[1], 32'h40);
        ready = 1'b1;
        cyc();
        chk("t5_head3c", d_pc[1], 32'h3C);
        cyc();
        chk("t5_empty", 32'(d_valid[1]), 32'h0);
        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) cyc();
        do_reset();
        cyc();
        chk("t6_restart_pc", d_pc[0], 32'h0);
        chk("t6_restart_addr", d_addr[0], 32'h4);
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
